// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: mux selects, stall FSM states, counter width.
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int CNT_W = 3;

  typedef enum logic {IDLE, STALL} state_t;
endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle for hazard_forward_unit: ID/EX/MEM/WB register fields in, mux selects and stall controls out.
interface hazard_forward_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC*REG_AW-1:0] rs_id;
  logic [NUM_SRC-1:0]        src_used_id;
  logic [NUM_SRC*REG_AW-1:0] rs_ex;
  logic [REG_AW-1:0]         rd_ex;
  logic                      mem_read_ex;
  logic [REG_AW-1:0]         rd_mem;
  logic                      reg_write_mem;
  logic [REG_AW-1:0]         rd_wb;
  logic                      reg_write_wb;
  logic                      flush;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall_if;
  logic                      stall_id;
  logic                      bubble_ex;

  modport master (
    output rs_id, src_used_id, rs_ex, rd_ex, mem_read_ex,
           rd_mem, reg_write_mem, rd_wb, reg_write_wb, flush,
    input  fwd_sel, stall_if, stall_id, bubble_ex
  );

  modport slave (
    input  rs_id, src_used_id, rs_ex, rd_ex, mem_read_ex,
           rd_mem, reg_write_mem, rd_wb, reg_write_wb, flush,
    output fwd_sel, stall_if, stall_id, bubble_ex
  );
endinterface

// File: rtl/hazard_forward_unit_operand_fwd_sel.sv
// Single-operand forwarding select: MEM beats WB, and register x0 is never forwarded.
module operand_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              reg_write_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              reg_write_wb,
  output logic [1:0]        sel
);
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = reg_write_mem && (rd_mem != '0) && (rd_mem == rs);
  assign wb_hit  = reg_write_wb  && (rd_wb  != '0) && (rd_wb  == rs);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end
endmodule

// File: rtl/hazard_forward_unit.sv
// Per-operand EX forwarding plus load-use stall FSM holding IF/ID for MEM_LAT cycles.
// Optional HAZARD_STATS_EN adds stall_cycles / fwd_events counters.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_forward_unit_if.slave bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          fwd_events
`endif
);
  localparam logic [CNT_W-1:0] CNT_INIT = (MEM_LAT > 1) ? CNT_W'(MEM_LAT - 2) : '0;

  logic [NUM_SRC*2-1:0] fwd_sel;
  logic                 hazard;
  logic                 stall;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_op
    operand_fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .rs            (bus.rs_ex[k*REG_AW +: REG_AW]),
      .rd_mem        (bus.rd_mem),
      .reg_write_mem (bus.reg_write_mem),
      .rd_wb         (bus.rd_wb),
      .reg_write_wb  (bus.reg_write_wb),
      .sel           (fwd_sel[k*2 +: 2])
    );
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.src_used_id[k] && (bus.rs_id[k*REG_AW +: REG_AW] == bus.rd_ex))
        hazard = 1'b1;
    end
    hazard = hazard && bus.mem_read_ex && (bus.rd_ex != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first stall cycle is spent in IDLE, so STALL only covers the remaining MEM_LAT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hazard) begin
            stall = 1'b1;
            if (MEM_LAT > 1) begin
              state_d = STALL;
              cnt_d   = CNT_INIT;
            end
          end
        end
        STALL: begin
          stall = 1'b1;
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (rst) stall = 1'b0;
  end

  assign bus.fwd_sel   = fwd_sel;
  assign bus.stall_if  = stall;
  assign bus.stall_id  = stall;
  assign bus.bubble_ex = stall;

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall)     stall_cycles <= stall_cycles + 32'd1;
      if (|fwd_sel)  fwd_events   <= fwd_events + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit at MEM_LAT 1, 3 and 4 with a queue-based scoreboard.
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(5), .NUM_SRC(2)) b1 ();
  hazard_forward_unit_if #(.REG_AW(5), .NUM_SRC(2)) b3 ();
  hazard_forward_unit_if #(.REG_AW(5), .NUM_SRC(2)) b4 ();

  assign b1.rs_id = b3.rs_id;             assign b4.rs_id = b3.rs_id;
  assign b1.src_used_id = b3.src_used_id; assign b4.src_used_id = b3.src_used_id;
  assign b1.rs_ex = b3.rs_ex;             assign b4.rs_ex = b3.rs_ex;
  assign b1.rd_ex = b3.rd_ex;             assign b4.rd_ex = b3.rd_ex;
  assign b1.mem_read_ex = b3.mem_read_ex; assign b4.mem_read_ex = b3.mem_read_ex;
  assign b1.rd_mem = b3.rd_mem;           assign b4.rd_mem = b3.rd_mem;
  assign b1.reg_write_mem = b3.reg_write_mem; assign b4.reg_write_mem = b3.reg_write_mem;
  assign b1.rd_wb = b3.rd_wb;             assign b4.rd_wb = b3.rd_wb;
  assign b1.reg_write_wb = b3.reg_write_wb;   assign b4.reg_write_wb = b3.reg_write_wb;
  assign b1.flush = b3.flush;             assign b4.flush = b3.flush;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles3, fwd_events3;
  logic [31:0] stall_cycles1, fwd_events1;
  logic [31:0] stall_cycles4, fwd_events4;
  int sc1 = 0, sc3 = 0, sc4 = 0, fe = 0;
`endif

  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles1), .fwd_events(fwd_events1)
`endif
  );
  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles3), .fwd_events(fwd_events3)
`endif
  );
  hazard_forward_unit #(.REG_AW(5), .NUM_SRC(2), .MEM_LAT(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles4), .fwd_events(fwd_events4)
`endif
  );

  typedef struct {
    logic [3:0] fwd;
    logic       s1;
    logic       s3;
    logic       s4;
  } exp_t;

  exp_t sb[$];
  int   rem1 = 0, rem3 = 0, rem4 = 0;

  function automatic logic hazard_model();
    logic h;
    h = 1'b0;
    for (int k = 0; k < 2; k++)
      if (b3.src_used_id[k] && b3.rs_id[k*5 +: 5] == b3.rd_ex) h = 1'b1;
    return h && b3.mem_read_ex && (b3.rd_ex != 5'd0);
  endfunction

  function automatic logic [3:0] fwd_model();
    logic [3:0] r;
    logic [4:0] s;
    r = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      s = b3.rs_ex[k*5 +: 5];
      if (b3.reg_write_mem && b3.rd_mem != 5'd0 && b3.rd_mem == s)   r[k*2 +: 2] = 2'b10;
      else if (b3.reg_write_wb && b3.rd_wb != 5'd0 && b3.rd_wb == s) r[k*2 +: 2] = 2'b01;
    end
    return r;
  endfunction

  function automatic int next_rem(input int rem, input logic hz, input int lat);
    if (rst || b3.flush) return 0;
    if (rem > 0)         return rem - 1;
    if (hz)              return lat - 1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_stall(input string tag, input logic si, input logic sd, input logic bx,
                           input logic exp);
    chk({tag, ".stall_if"},  {31'd0, si}, {31'd0, exp});
    chk({tag, ".stall_id"},  {31'd0, sd}, {31'd0, exp});
    chk({tag, ".bubble_ex"}, {31'd0, bx}, {31'd0, exp});
  endtask

  // One clock: predict, push, sample on the falling edge, pop and compare, then advance.
  task automatic cycle(input string tag);
    exp_t e;
    logic hz;
    hz    = hazard_model();
    e.fwd = fwd_model();
    e.s1  = !rst && !b3.flush && (rem1 > 0 || hz);
    e.s3  = !rst && !b3.flush && (rem3 > 0 || hz);
    e.s4  = !rst && !b3.flush && (rem4 > 0 || hz);
    sb.push_back(e);
    rem1 = next_rem(rem1, hz, 1);
    rem3 = next_rem(rem3, hz, 3);
    rem4 = next_rem(rem4, hz, 4);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".fwd1"}, {28'd0, b1.fwd_sel}, {28'd0, e.fwd});
    chk({tag, ".fwd3"}, {28'd0, b3.fwd_sel}, {28'd0, e.fwd});
    chk({tag, ".fwd4"}, {28'd0, b4.fwd_sel}, {28'd0, e.fwd});
    chk_stall({tag, ".lat1"}, b1.stall_if, b1.stall_id, b1.bubble_ex, e.s1);
    chk_stall({tag, ".lat3"}, b3.stall_if, b3.stall_id, b3.bubble_ex, e.s3);
    chk_stall({tag, ".lat4"}, b4.stall_if, b4.stall_id, b4.bubble_ex, e.s4);
`ifdef HAZARD_STATS_EN
    chk({tag, ".stall_cycles1"}, stall_cycles1, sc1);
    chk({tag, ".stall_cycles3"}, stall_cycles3, sc3);
    chk({tag, ".stall_cycles4"}, stall_cycles4, sc4);
    chk({tag, ".fwd_events3"},   fwd_events3,   fe);
    sc1 = rst ? 0 : sc1 + int'(e.s1);
    sc3 = rst ? 0 : sc3 + int'(e.s3);
    sc4 = rst ? 0 : sc4 + int'(e.s4);
    fe  = rst ? 0 : fe  + int'(e.fwd != 4'b0000);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input logic [4:0] rs1, input logic [4:0] rs0,
                         input logic [4:0] rdm, input logic wm,
                         input logic [4:0] rdw, input logic ww);
    b3.rs_ex = {rs1, rs0};
    b3.rd_mem = rdm; b3.reg_write_mem = wm;
    b3.rd_wb = rdw;  b3.reg_write_wb = ww;
  endtask

  task automatic set_ld(input logic mr, input logic [4:0] rdex,
                        input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used);
    b3.mem_read_ex = mr; b3.rd_ex = rdex;
    b3.rs_id = {rs1, rs0}; b3.src_used_id = used;
  endtask

  initial begin
    rst = 1'b1;
    b3.flush = 1'b0;
    set_fwd(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    @(posedge clk);
    #1;

    // Hazard present while in reset: no stall.
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 2'b10);
    cycle("rst_hazard");
    cycle("rst_hazard2");
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    cycle("rst_idle");
    rst = 1'b0;
    cycle("post_rst");

    set_fwd(5'd5, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1); cycle("mem_prio");
    set_fwd(5'd0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1); cycle("x0_indep");
    set_fwd(5'd3, 5'd4, 5'd4, 1'b1, 5'd3, 1'b1); cycle("split");
    set_fwd(5'd6, 5'd6, 5'd6, 1'b0, 5'd6, 1'b1); cycle("wb_only");
    set_fwd(5'd6, 5'd6, 5'd6, 1'b0, 5'd6, 1'b0); cycle("no_write");
    set_fwd(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1); cycle("x0_both");
    set_fwd(5'd31, 5'd1, 5'd31, 1'b1, 5'd2, 1'b1); cycle("max_addr");

    // Single load-use, with forwarding activity during the stall.
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 2'b10);
    cycle("lu_hit");
    set_ld(1'b0, 5'd0, 5'd9, 5'd0, 2'b10);
    set_fwd(5'd9, 5'd2, 5'd9, 1'b1, 5'd2, 1'b1);
    for (int i = 0; i < 5; i++) cycle("lu_tail");
    set_fwd(5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);

    // Matching register but operand not read: no stall.
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 2'b01);
    cycle("lu_unused");
    cycle("lu_unused2");
    set_ld(1'b1, 5'd0, 5'd0, 5'd0, 2'b11);
    cycle("lu_x0");
    set_ld(1'b0, 5'd9, 5'd9, 5'd9, 2'b11);
    cycle("no_load");

    // Hazard held continuously: ignored mid-stall, re-armed afterwards.
    set_ld(1'b1, 5'd12, 5'd0, 5'd12, 2'b01);
    for (int i = 0; i < 7; i++) cycle("lu_hold");
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 5; i++) cycle("hold_tail");

    // Flush in the second stall cycle.
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 2'b10);
    cycle("fl_hit");
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    b3.flush = 1'b1;
    cycle("fl_pulse");
    b3.flush = 1'b0;
    for (int i = 0; i < 4; i++) cycle("fl_after");

    // Flush coincident with a fresh hazard.
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 2'b10);
    b3.flush = 1'b1;
    cycle("fl_hazard");
    b3.flush = 1'b0;
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 2; i++) cycle("fl_hz_after");

    // Reset mid-stall.
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 2'b10);
    cycle("rs_hit");
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    cycle("rs_mid");
    rst = 1'b1;
    cycle("rs_pulse");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle("rs_after");

    // Back-to-back load-use hazards, each a full independent stall.
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 2'b10);
    cycle("b2b_first");
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 4; i++) cycle("b2b_gap");
    set_ld(1'b1, 5'd10, 5'd0, 5'd10, 2'b01);
    cycle("b2b_second");
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    for (int i = 0; i < 5; i++) cycle("b2b_tail");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
